posit16_1_mac_stream: RTL and testbench

//  Streaming posit<16,1> multiply-accumulate: per beat, multiplies two decoded posits exactly and adds the product into a 128-bit quire.
//  A window is framed by sow_i/eow_i; one quire result is emitted per window.

---
 rtl/posit16_1_mac_stream.sv | 123 ++++++++++++
 tb/tb_posit16_1_mac_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/posit16_1_mac_stream.sv
// Streaming posit<16,1> multiply-accumulate into a 128-bit quire.
// One result per sow/eow-framed window; the whole pipe stalls while a result is unaccepted.
module posit16_1_mac_stream #(
   parameter int unsigned FRAC_W  = 12,
   parameter int unsigned SCALE_W = 6,
   parameter int unsigned QUIRE_W = 128,
   parameter int unsigned QFRAC   = 56
) (
   input  logic               tb_clk,
   input  logic               tb_reset_n,
   input  logic               rts_i,
   output logic               rtr_o,
   input  logic               sow_i,
   input  logic               eow_i,
   input  logic               sign_i1,
   input  logic               sign_i2,
   input  logic [SCALE_W-1:0] scale_i1,
   input  logic [SCALE_W-1:0] scale_i2,
   input  logic [FRAC_W-1:0]  fraction_i1,
   input  logic [FRAC_W-1:0]  fraction_i2,
   input  logic               zero_i1,
   input  logic               zero_i2,
   input  logic               NaR_i1,
   input  logic               NaR_i2,
   input  logic               rtr_i,
   output logic               rts_o,
   output logic               sow_o,
   output logic               eow_o,
   output logic [QUIRE_W-1:0] quire_o
);

   localparam int unsigned PROD_W = 2 * (FRAC_W + 1);
   localparam int unsigned SUM_W  = SCALE_W + 1;
   localparam int unsigned SH_W   = 8;
   // Product LSB weight is 2^-(2*FRAC_W); align it to the quire LSB weight 2^-QFRAC.
   localparam int unsigned OFFSET = QFRAC - 2 * FRAC_W;
   localparam logic [QUIRE_W-1:0] NAR_PAT = {1'b1, (QUIRE_W-1)'(0)};

   logic                      adv_c;
   logic                      s1_vld_q, s1_sow_q, s1_eow_q, s1_sign_q, s1_nar_q, s1_zero_q;
   logic [PROD_W-1:0]         s1_prod_q;
   logic signed [SUM_W-1:0]   s1_scale_q;
   logic signed [SH_W-1:0]    sh_c;
   logic [SH_W-1:0]           shamt_c;
   logic [QUIRE_W-1:0]        mag_c, term_c, acc_d, acc_q;
   logic                      nar_d, nar_q, s2_eow_q;
   logic                      rts_q;
   logic [QUIRE_W-1:0]        quire_q;

   assign rtr_o   = ~(rts_q & ~rtr_i);
   assign adv_c   = rtr_o;
   assign rts_o   = rts_q;
   assign sow_o   = rts_q;
   assign eow_o   = rts_q;
   assign quire_o = quire_q;

   // Stage 1: exact significand product and scale sum
   always_ff @(posedge tb_clk or negedge tb_reset_n) begin
      if (!tb_reset_n) begin
         s1_vld_q   <= 1'b0;
         s1_sow_q   <= 1'b0;
         s1_eow_q   <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_nar_q   <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_prod_q  <= '0;
         s1_scale_q <= '0;
      end else if (adv_c) begin
         s1_vld_q   <= rts_i;
         s1_sow_q   <= sow_i;
         s1_eow_q   <= eow_i;
         s1_sign_q  <= sign_i1 ^ sign_i2;
         s1_nar_q   <= NaR_i1 | NaR_i2;
         s1_zero_q  <= (zero_i1 | zero_i2) & ~(NaR_i1 | NaR_i2);
         s1_prod_q  <= PROD_W'({1'b1, fraction_i1}) * PROD_W'({1'b1, fraction_i2});
         s1_scale_q <= SUM_W'($signed(scale_i1)) + SUM_W'($signed(scale_i2));
      end
   end

   // Stage 2: align product into the quire field and fold into the window sum
   always_comb begin
      sh_c    = SH_W'(s1_scale_q) + $signed(SH_W'(OFFSET));
      shamt_c = sh_c[SH_W-1] ? SH_W'(-sh_c) : SH_W'(sh_c);
      mag_c   = sh_c[SH_W-1] ? (QUIRE_W'(s1_prod_q) >> shamt_c)
                             : (QUIRE_W'(s1_prod_q) << shamt_c);
      term_c  = '0;
      if (!(s1_zero_q | s1_nar_q)) begin
         term_c = s1_sign_q ? -mag_c : mag_c;
      end
      acc_d = acc_q;
      nar_d = nar_q;
      if (s1_vld_q) begin
         acc_d = s1_sow_q ? term_c : acc_q + term_c;
         nar_d = s1_sow_q ? s1_nar_q : (nar_q | s1_nar_q);
      end
   end

   always_ff @(posedge tb_clk or negedge tb_reset_n) begin
      if (!tb_reset_n) begin
         acc_q    <= '0;
         nar_q    <= 1'b0;
         s2_eow_q <= 1'b0;
      end else if (adv_c) begin
         acc_q    <= acc_d;
         nar_q    <= nar_d;
         s2_eow_q <= s1_vld_q & s1_eow_q;
      end
   end

   // Output register: loaded one cycle after the closing beat leaves stage 2
   always_ff @(posedge tb_clk or negedge tb_reset_n) begin
      if (!tb_reset_n) begin
         rts_q   <= 1'b0;
         quire_q <= '0;
      end else if (adv_c) begin
         rts_q <= s2_eow_q;
         if (s2_eow_q) begin
            quire_q <= nar_q ? NAR_PAT : acc_q;
         end
      end
   end

endmodule

// File: tb/tb_posit16_1_mac_stream.sv
// Directed self-checking bench for posit16_1_mac_stream.
module tb_posit16_1_mac_stream;

   logic         tb_clk = 1'b0;
   logic         tb_reset_n = 1'b0;
   logic         rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0;
   logic         sign_i1 = 1'b0, sign_i2 = 1'b0;
   logic [5:0]   scale_i1 = '0, scale_i2 = '0;
   logic [11:0]  fraction_i1 = '0, fraction_i2 = '0;
   logic         zero_i1 = 1'b0, zero_i2 = 1'b0, NaR_i1 = 1'b0, NaR_i2 = 1'b0;
   logic         rtr_i = 1'b1;
   logic         rtr_o, rts_o, sow_o, eow_o;
   logic [127:0] quire_o;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] ONE     = 128'd1 << 56;
   localparam logic [127:0] NAR_PAT = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

   posit16_1_mac_stream dut (
      .tb_clk(tb_clk), .tb_reset_n(tb_reset_n),
      .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
      .sign_i1(sign_i1), .sign_i2(sign_i2),
      .scale_i1(scale_i1), .scale_i2(scale_i2),
      .fraction_i1(fraction_i1), .fraction_i2(fraction_i2),
      .zero_i1(zero_i1), .zero_i2(zero_i2),
      .NaR_i1(NaR_i1), .NaR_i2(NaR_i2),
      .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
      .quire_o(quire_o)
   );

   always #5 tb_clk = ~tb_clk;

   // Drive one beat; returns 1 time unit after the accepting edge.
   task automatic beat(input logic sw, input logic ew,
                       input logic sg1, input logic [5:0] sc1, input logic [11:0] f1,
                       input logic z1, input logic n1,
                       input logic sg2, input logic [5:0] sc2, input logic [11:0] f2,
                       input logic z2, input logic n2);
      logic took;
      @(negedge tb_clk);
      rts_i = 1'b1; sow_i = sw; eow_i = ew;
      sign_i1 = sg1; scale_i1 = sc1; fraction_i1 = f1; zero_i1 = z1; NaR_i1 = n1;
      sign_i2 = sg2; scale_i2 = sc2; fraction_i2 = f2; zero_i2 = z2; NaR_i2 = n2;
      took = 1'b0;
      for (int n = 0; n < 100; n++) begin
         took = rtr_o;
         @(posedge tb_clk);
         if (took) break;
         @(negedge tb_clk);
      end
      checks++;
      if (!took) begin
         errors++;
         $display("FAIL beat_accept: rtr_o never high within 100 cycles");
      end
      #1;
      rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0;
   endtask

   // Called right after the eow beat is accepted at edge N; expects the result at N+2.
   task automatic expect_result(input logic [127:0] exp, input string name);
      @(posedge tb_clk); #1;
      checks++;
      if (rts_o !== 1'b0) begin
         errors++; $display("FAIL %s_early: rts_o=%b want 0 at N+1", name, rts_o);
      end
      @(posedge tb_clk); #1;
      checks++;
      if ({rts_o, sow_o, eow_o} !== 3'b111) begin
         errors++; $display("FAIL %s_valid: rts/sow/eow=%b want 111", name, {rts_o, sow_o, eow_o});
      end
      checks++;
      if (quire_o !== exp) begin
         errors++; $display("FAIL %s_quire: got %h want %h", name, quire_o, exp);
      end
      @(posedge tb_clk); #1;
      checks++;
      if (rts_o !== 1'b0) begin
         errors++; $display("FAIL %s_drop: rts_o=%b want 0", name, rts_o);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({rts_o, sow_o, eow_o} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {rts_o, sow_o, eow_o});
      end
      checks++;
      if (quire_o !== '0) begin
         errors++; $display("FAIL reset_quire: got %h want 0", quire_o);
      end
      repeat (2) @(negedge tb_clk);
      tb_reset_n = 1'b1;
      #1;
      checks++;
      if (rtr_o !== 1'b1) begin
         errors++; $display("FAIL reset_rtr: got %b want 1", rtr_o);
      end
   endtask

   task automatic test_single();
      beat(1, 1, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      expect_result(ONE, "one_x_one");
   endtask

   task automatic test_window3();
      beat(1, 0, 0, 6'd0, 12'h800, 0, 0, 0, 6'd1, 12'h000, 0, 0);
      beat(0, 0, 1, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(0, 1, 0, 6'd0, 12'h000, 1, 0, 0, 6'd5, 12'h123, 0, 0);
      expect_result(ONE << 1, "window3");
   endtask

   task automatic test_extremes();
      beat(1, 1, 0, 6'h24, 12'h000, 0, 0, 0, 6'h24, 12'h000, 0, 0);
      expect_result(128'h1, "minpos_sq");
      beat(1, 1, 0, 6'h1C, 12'h000, 0, 0, 0, 6'h1C, 12'h000, 0, 0);
      expect_result(128'd1 << 112, "maxpos_sq");
   endtask

   task automatic test_nar();
      beat(1, 0, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(0, 0, 0, 6'd0, 12'h000, 0, 1, 0, 6'd0, 12'h000, 0, 0);
      beat(0, 0, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(0, 1, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      expect_result(NAR_PAT, "nar_window");
      beat(1, 1, 1, 6'd0, 12'h000, 0, 0, 0, 6'd1, 12'h000, 0, 0);
      expect_result(-(ONE << 1), "after_nar");
   endtask

   task automatic test_restart();
      beat(1, 0, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(0, 0, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(1, 0, 0, 6'd1, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(0, 1, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      expect_result(ONE * 3, "restart");
   endtask

   task automatic test_back_to_back_stall();
      rtr_i = 1'b0;
      beat(1, 1, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(1, 1, 0, 6'd1, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(1, 1, 1, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({rts_o, rtr_o} !== 2'b10 || quire_o !== ONE) begin
            errors++;
            $display("FAIL stall_hold: rts_o=%b rtr_o=%b quire=%h want 1 0 %h",
                     rts_o, rtr_o, quire_o, ONE);
         end
         @(posedge tb_clk); #1;
      end
      @(negedge tb_clk);
      rtr_i = 1'b1;
      @(posedge tb_clk); #1;
      checks++;
      if (rts_o !== 1'b1 || quire_o !== (ONE << 1)) begin
         errors++; $display("FAIL stall_second: rts_o=%b quire=%h want 1 %h", rts_o, quire_o, ONE << 1);
      end
      @(posedge tb_clk); #1;
      checks++;
      if (rts_o !== 1'b1 || quire_o !== -ONE) begin
         errors++; $display("FAIL stall_third: rts_o=%b quire=%h want 1 %h", rts_o, quire_o, -ONE);
      end
      @(posedge tb_clk); #1;
      checks++;
      if (rts_o !== 1'b0) begin
         errors++; $display("FAIL stall_drain: rts_o=%b want 0", rts_o);
      end
   endtask

   task automatic test_reset_mid_window();
      rtr_i = 1'b0;
      beat(1, 1, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      beat(1, 0, 0, 6'd0, 12'h000, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      @(posedge tb_clk); #1;
      checks++;
      if (rts_o !== 1'b1) begin
         errors++; $display("FAIL midrst_pre: rts_o=%b want 1", rts_o);
      end
      @(negedge tb_clk);
      tb_reset_n = 1'b0;
      #1;
      checks++;
      if (rts_o !== 1'b0 || quire_o !== '0 || rtr_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_clear: rts_o=%b quire=%h rtr_o=%b want 0 0 1", rts_o, quire_o, rtr_o);
      end
      @(negedge tb_clk);
      tb_reset_n = 1'b1;
      rtr_i = 1'b1;
      // No sow: accumulates onto the acc that reset cleared
      beat(0, 1, 0, 6'd0, 12'h800, 0, 0, 0, 6'd0, 12'h000, 0, 0);
      expect_result(ONE + (ONE >> 1), "after_reset");
   endtask

   initial begin
      test_reset();
      test_single();
      test_window3();
      test_extremes();
      test_nar();
      test_restart();
      test_back_to_back_stall();
      test_reset_mid_window();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
